// File: rtl/arbitro_round_robin_pkg.sv
// arbitro_round_robin_pkg: state encoding and index/rotation helpers shared by the arbiter files.
package arbitro_round_robin_pkg;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Explicit wrap keeps the pointer below n even when n is not a power of two.
    function automatic int rot_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction

endpackage

// File: rtl/arbitro_round_robin_codificador_rotativo.sv
// codificador_rotativo: first set request bit at or after pointer, with wrap and an optional masked index.
module codificador_rotativo
    import arbitro_round_robin_pkg::*;
#(
    parameter  int number_ports = 4,
    localparam int idx_w        = idx_width(number_ports)
) (
    input  logic [number_ports-1:0] request,
    input  logic [idx_w-1:0]        pointer,
    input  logic [idx_w-1:0]        mask_index,
    input  logic                    mask_en,
    output logic                    found,
    output logic [idx_w-1:0]        chosen
);

    logic [idx_w-1:0] cand;

    // Scan from the farthest offset down so the nearest candidate is written last and wins.
    always_comb begin
        found  = 1'b0;
        chosen = '0;
        cand   = '0;
        for (int k = number_ports - 1; k >= 0; k--) begin
            cand = idx_w'(wrap_add(int'(pointer), k, number_ports));
            if (request[cand] && !(mask_en && cand == mask_index)) begin
                found  = 1'b1;
                chosen = cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_round_robin.sv
// arbitro_round_robin: round-robin arbiter with hold limit; registered one-hot grant and mux select index.
module arbitro_round_robin
    import arbitro_round_robin_pkg::*;
#(
    parameter  int number_ports = 4,
    parameter  int max_hold     = 8,
    localparam int idx_w        = idx_width(number_ports),
    localparam int hw_w         = $clog2(max_hold + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [number_ports-1:0] request,
    output logic [number_ports-1:0] grant,
    output logic [idx_w-1:0]        grant_index,
    output logic                    grant_valid,
    output logic [hw_w-1:0]         hold_count
);

    arb_state_e              state_q;
    logic [idx_w-1:0]        ptr_q, idx_q, ptr_d, search_from, chosen;
    logic [number_ports-1:0] grant_q;
    logic                    valid_q, found;
    logic [hw_w-1:0]         hold_q;

    // While granted, the search starts after the owner and skips it, so found means real contention.
    assign ptr_d       = idx_w'(rot_inc(int'(idx_q), number_ports));
    assign search_from = (state_q == ARB_GRANT) ? ptr_d : ptr_q;

    codificador_rotativo #(.number_ports(number_ports)) u_enc (
        .request    (request),
        .pointer    (search_from),
        .mask_index (idx_q),
        .mask_en    (state_q == ARB_GRANT),
        .found      (found),
        .chosen     (chosen)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (found) begin
                state_q <= ARB_GRANT;
                grant_q <= number_ports'(1) << chosen;
                idx_q   <= chosen;
                valid_q <= 1'b1;
                hold_q  <= hw_w'(1);
            end
        end else if (!request[idx_q]) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= ptr_d;
        end else if (hold_q == hw_w'(max_hold) && found) begin
            grant_q <= number_ports'(1) << chosen;
            idx_q   <= chosen;
            hold_q  <= hw_w'(1);
            ptr_q   <= ptr_d;
        end else if (hold_q != hw_w'(max_hold)) begin
            hold_q <= hold_q + 1'b1;
        end
    end

    assign grant       = grant_q;
    assign grant_index = idx_q;
    assign grant_valid = valid_q;
    assign hold_count  = hold_q;

endmodule

// File: doc/arbitro_round_robin.md
Name: arbitro_round_robin

Overview:
- Round-robin arbiter that shares one output resource (a router output port) between number_ports requesters.
- A rotating priority pointer selects the first requester at or after the pointer. The selected requester keeps the grant while its request stays high.
- A hold counter forces the grant to rotate after max_hold cycles if another requester is waiting.
- All outputs are registered. It sits in front of the output crossbar mux, and grant_index drives the mux select.

Parameters:
- number_ports, 4, number of requesters (minimum 2).
- max_hold, 8, maximum consecutive granted cycles before forced rotation when contention exists (minimum 1).
- idx_w, $clog2(number_ports), width of index signals (derived, not overridable).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous reset, active-low; all state clears immediately on assertion.
- request  input  number_ports  per-port request, level-sensitive, bit i = port i.
- grant  output  number_ports  one-hot grant, or all zero.
- grant_index  output  idx_w  binary index of the granted port; holds its last value while grant_valid=0.
- grant_valid  output  1  high while any grant bit is high.
- hold_count  output  $clog2(max_hold+1)  cycles the current owner has held the grant (debug/perf).

Behaviour:
- Reset values: grant=0, grant_index=0, grant_valid=0, hold_count=0, pointer=0, state=IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If request!=0, the next edge enters GRANT.
  - The owner is the first i in pointer, pointer+1, ... wrapping modulo number_ports with request[i]=1.
  - On that edge: grant[owner]=1, grant_index=owner, grant_valid=1, hold_count=1.
  - Latency is one cycle from request to grant. If request==0, stay in IDLE.
- GRANT, owner still requesting, and either hold_count<max_hold or no other request bit set:
  - Stay in GRANT.
  - hold_count increments, saturating at max_hold.
- GRANT, owner drops request:
  - The next edge goes to IDLE with grant=0 and grant_valid=0.
  - pointer = (owner+1) mod number_ports.
  - There is exactly one bubble cycle; no back-to-back handover without the bubble.
- GRANT, forced rotation: owner requesting, hold_count==max_hold, and another request bit set.
  - The next edge goes directly to a new GRANT.
  - The new owner is the first requester searching from (owner+1) mod number_ports, excluding the old owner.
  - hold_count=1 and pointer=(old owner+1) mod number_ports. There is no bubble.
- Wrap-around: the search from pointer=number_ports-1 continues at 0.
- Non-power-of-2 number_ports: the pointer never takes values >= number_ports, and increment wraps explicitly.
- Simultaneous events: the owner dropping its request in the same cycle as the max_hold condition takes the release path (IDLE, bubble).
- Request bits of non-owners are sampled only at decision points; glitches mid-grant have no effect.
- Reset mid-grant: outputs clear asynchronously. The first arbitration after release of reset_n starts from pointer=0.
- Invariants: grant is always one-hot or zero; grant_valid == |grant.

Decomposition:
- Shared package/header holds:
  - state encoding constants ARB_IDLE=1'b0, ARB_GRANT=1'b1;
  - width function/constant for idx_w;
  - the rotation increment macro.
- One sub-module, codificador_rotativo, is combinational.
  - Inputs: request, pointer, mask_index, mask_en.
  - Outputs: found and chosen index.
  - It finds the first set bit at or after pointer with wrap, optionally masking one index.
  - It is instantiated once in the arbiter.
- The FSM, pointer register, hold counter and output registers live in arbitro_round_robin.

Test Plan:
1. number_ports=4, reset, request=4'b0101 held for one cycle then kept -> next edge grant=4'b0001, grant_index=0, grant_valid=1, hold_count=1.
2. Owner 0 drops request with request=4'b0100 -> next cycle grant=0 (bubble), pointer=1; following edge grant=4'b0100, grant_index=2.
3. Wrap: pointer=3, request=4'b0011 -> grant=4'b0001, not 4'b0010.
4. max_hold=4, request=4'b1001 constant from IDLE with pointer=0:
   - grant=4'b0001 for 4 cycles, hold_count goes 1..4;
   - then grant=4'b1000 with no bubble and hold_count=1;
   - after 4 more cycles grant returns to 4'b0001.
5. Single requester request=4'b0010 held for 20 cycles -> grant stays 4'b0010 and hold_count saturates at 4 with no rotation.
6. Assert reset_n low mid-grant, asynchronously between edges -> grant, grant_valid and hold_count read 0 before the next edge. After release with request=4'b1110, the first grant is 4'b0010.
